writeback_regfile_stage: RTL and testbench

//   WB stage of the 5-stage RV32I pipeline, directly downstream of the MEM/WB register.
//   - Formats load data, selects the write-back result and writes the integer register file.
//   - Serves the two decode-stage read ports, with same-cycle write-through bypass.
//   - Exports ResultW for EX-stage forwarding; counts retired instructions.

---
 rtl/writeback_regfile_stage_pkg.sv | 29 ++
 rtl/writeback_regfile_stage_if.sv | 26 ++
 rtl/writeback_regfile_stage_regfile.sv | 28 ++
 rtl/writeback_regfile_stage.sv | 33 +++
 tb/tb_writeback_regfile_stage.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/writeback_regfile_stage_pkg.sv
// writeback_regfile_stage_pkg: shared ResultSrc/load encodings and the load formatter.
package writeback_regfile_stage_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int INSTRET_W = 64;
    localparam int AW = $clog2(NREGS);
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_ALT  = 2'b11
    } result_src_e;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Halfword select uses only off[1]; misaligned halfwords are not trapped here.
    function automatic logic [XLEN-1:0] format_load(logic [2:0] f3, logic [1:0] off, logic [XLEN-1:0] w);
        logic [7:0] b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        return f3 == F3_LB  ? {{24{b[7]}}, b} :
               f3 == F3_LBU ? {24'b0, b} :
               f3 == F3_LH  ? {{16{h[15]}}, h} :
               f3 == F3_LHU ? {16'b0, h} : w;
    endfunction
endpackage

// File: rtl/writeback_regfile_stage_if.sv
// writeback_regfile_stage_if: MEM/WB inputs, decode read ports and WB outputs of the stage.
interface writeback_regfile_stage_if;
    import writeback_regfile_stage_pkg::*;
    logic ValidW;
    logic RegWriteW;
    logic [1:0] ResultSrcW;
    logic [2:0] LoadFunct3W;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;
    logic [AW-1:0] RdW;
    logic [AW-1:0] Rs1D;
    logic [AW-1:0] Rs2D;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ResultW;
    logic [INSTRET_W-1:0] InstretCount;
    modport master (
        output ValidW, RegWriteW, ResultSrcW, LoadFunct3W, ALUResultW, ReadDataW, PCPlus4W, RdW, Rs1D, Rs2D,
        input RD1D, RD2D, ResultW, InstretCount
    );
    modport slave (
        input ValidW, RegWriteW, ResultSrcW, LoadFunct3W, ALUResultW, ReadDataW, PCPlus4W, RdW, Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, InstretCount
    );
endinterface

// File: rtl/writeback_regfile_stage_regfile.sv
// regfile_2r1w: 2-read 1-write register file, async clear, x0 tied to zero, write-through bypass.
module regfile_2r1w #(
    parameter int NREGS = 32,
    parameter int XLEN = 32,
    parameter int AW = $clog2(NREGS)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic we,
    input  logic [AW-1:0] wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREGS];
    logic wen;
    assign wen = we && wa != '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (wen)
            regs[wa] <= wd;
    end
    assign rd1 = ra1 == '0 ? '0 : (wen && ra1 == wa) ? wd : regs[ra1];
    assign rd2 = ra2 == '0 ? '0 : (wen && ra2 == wa) ? wd : regs[ra2];
endmodule

// File: rtl/writeback_regfile_stage.sv
// writeback_regfile_stage: RV32I WB stage - load format, result select, regfile write/read, instret.
module writeback_regfile_stage
    import writeback_regfile_stage_pkg::*;
(
    input logic clk,
    input logic reset_n,
    writeback_regfile_stage_if.slave bus
);
    logic [XLEN-1:0] load_data;
    logic [INSTRET_W-1:0] instret;
    assign load_data = format_load(bus.LoadFunct3W, bus.ALUResultW[1:0], bus.ReadDataW);
    // Code 11 is a reserved alias of the ALU path.
    assign bus.ResultW = bus.ResultSrcW == RES_LOAD ? load_data :
                         bus.ResultSrcW == RES_PC4  ? bus.PCPlus4W : bus.ALUResultW;
    regfile_2r1w #(.NREGS(NREGS), .XLEN(XLEN), .AW(AW)) u_rf (
        .clk(clk),
        .reset_n(reset_n),
        .we(bus.ValidW && bus.RegWriteW),
        .wa(bus.RdW),
        .wd(bus.ResultW),
        .ra1(bus.Rs1D),
        .ra2(bus.Rs2D),
        .rd1(bus.RD1D),
        .rd2(bus.RD2D)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            instret <= '0;
        else if (bus.ValidW)
            instret <= instret + 1'b1;
    end
    assign bus.InstretCount = instret;
endmodule

// File: tb/tb_writeback_regfile_stage.sv
// tb_writeback_regfile_stage: directed vector table plus hand sequences for the WB stage.
module tb_writeback_regfile_stage;
    logic clk = 0;
    logic reset_n = 0;
    int tests = 0;
    int fails = 0;
    writeback_regfile_stage_if bus();
    writeback_regfile_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] src;
        logic [2:0] f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        bus.ResultSrcW = 2'b00;
        bus.ALUResultW = val;
        bus.RdW = rd;
        bus.ValidW = 1;
        bus.RegWriteW = 1;
        step();
        bus.ValidW = 0;
        bus.RegWriteW = 0;
    endtask

    initial begin
        logic [9:0] pat;
        pat = 10'b1101101101;
        vecs[0]  = '{2'b01, 3'b000, 32'h3, 32'h80FF7F01, 32'h0, 32'hFFFFFF80};
        vecs[1]  = '{2'b01, 3'b100, 32'h3, 32'h80FF7F01, 32'h0, 32'h00000080};
        vecs[2]  = '{2'b01, 3'b001, 32'h2, 32'h80FF7F01, 32'h0, 32'hFFFF80FF};
        vecs[3]  = '{2'b01, 3'b101, 32'h0, 32'h80FF7F01, 32'h0, 32'h00007F01};
        vecs[4]  = '{2'b01, 3'b001, 32'h3, 32'h80FF7F01, 32'h0, 32'hFFFF80FF};
        vecs[5]  = '{2'b01, 3'b000, 32'h0, 32'h80FF7F01, 32'h0, 32'h00000001};
        vecs[6]  = '{2'b01, 3'b000, 32'h1, 32'h80FF7F01, 32'h0, 32'h0000007F};
        vecs[7]  = '{2'b01, 3'b100, 32'h2, 32'h80FF7F01, 32'h0, 32'h000000FF};
        vecs[8]  = '{2'b01, 3'b000, 32'h2, 32'h80FF7F01, 32'h0, 32'hFFFFFFFF};
        vecs[9]  = '{2'b01, 3'b010, 32'h0, 32'h80FF7F01, 32'h0, 32'h80FF7F01};
        vecs[10] = '{2'b01, 3'b011, 32'h1, 32'h80FF7F01, 32'h0, 32'h80FF7F01};
        vecs[11] = '{2'b01, 3'b101, 32'h2, 32'h80FF7F01, 32'h0, 32'h000080FF};
        vecs[12] = '{2'b00, 3'b000, 32'h12345678, 32'h80FF7F01, 32'h104, 32'h12345678};
        vecs[13] = '{2'b10, 3'b000, 32'h12345678, 32'h80FF7F01, 32'h104, 32'h00000104};
        vecs[14] = '{2'b11, 3'b000, 32'hCAFEF00D, 32'h80FF7F01, 32'h104, 32'hCAFEF00D};

        bus.ValidW = 0; bus.RegWriteW = 0; bus.ResultSrcW = 0; bus.LoadFunct3W = 0;
        bus.ALUResultW = 0; bus.ReadDataW = 0; bus.PCPlus4W = 0; bus.RdW = 0;
        bus.Rs1D = 0; bus.Rs2D = 0;
        #12 reset_n = 1;

        for (int i = 0; i < 32; i++) begin
            bus.Rs1D = 5'(i);
            bus.Rs2D = 5'(31 - i);
            #1;
            chk("reset_rd1", {32'b0, bus.RD1D}, 64'd0);
            chk("reset_rd2", {32'b0, bus.RD2D}, 64'd0);
        end
        chk("reset_instret", bus.InstretCount, 64'd0);
        chk("reset_result", {32'b0, bus.ResultW}, 64'd0);

        for (int i = 0; i < 15; i++) begin
            bus.ResultSrcW = vecs[i].src;
            bus.LoadFunct3W = vecs[i].f3;
            bus.ALUResultW = vecs[i].alu;
            bus.ReadDataW = vecs[i].rdata;
            bus.PCPlus4W = vecs[i].pc4;
            #1;
            chk($sformatf("vec%0d_result", i), {32'b0, bus.ResultW}, {32'b0, vecs[i].exp});
        end

        step();
        bus.ResultSrcW = 0; bus.ALUResultW = 32'h12345678; bus.RdW = 5;
        bus.Rs1D = 5; bus.Rs2D = 5; bus.ValidW = 1; bus.RegWriteW = 1;
        #1;
        chk("bypass_rd1", {32'b0, bus.RD1D}, 64'h12345678);
        chk("bypass_rd2", {32'b0, bus.RD2D}, 64'h12345678);
        step();
        bus.ValidW = 0; bus.RegWriteW = 0; bus.ALUResultW = 0;
        #1;
        chk("stored_x5", {32'b0, bus.RD1D}, 64'h12345678);

        bus.Rs1D = 0; bus.Rs2D = 0;
        bus.ALUResultW = 32'hDEADBEEF; bus.RdW = 0; bus.ValidW = 1; bus.RegWriteW = 1;
        #1;
        chk("x0_bypass", {32'b0, bus.RD1D}, 64'd0);
        step();
        bus.ValidW = 0; bus.RegWriteW = 0;
        #1;
        chk("x0_stored", {32'b0, bus.RD1D}, 64'd0);

        write_reg(7, 32'h00000077);
        bus.Rs1D = 7; bus.ALUResultW = 32'h00000BAD; bus.RdW = 7; bus.RegWriteW = 1; bus.ValidW = 0;
        #1;
        chk("flush_nobypass", {32'b0, bus.RD1D}, 64'h77);
        step();
        bus.RegWriteW = 0;
        #1;
        chk("flush_x7", {32'b0, bus.RD1D}, 64'h77);

        bus.ResultSrcW = 2'b10; bus.PCPlus4W = 32'h104; bus.RdW = 1; bus.ValidW = 1; bus.RegWriteW = 1;
        step();
        bus.ValidW = 0; bus.RegWriteW = 0; bus.ResultSrcW = 0; bus.Rs2D = 1;
        #1;
        chk("pc4_x1", {32'b0, bus.RD2D}, 64'h104);

        #2 reset_n = 0;
        #2 reset_n = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.ValidW = pat[9 - i];
            step();
        end
        bus.ValidW = 0;
        chk("instret_7", bus.InstretCount, 64'd7);

        bus.Rs1D = 9;
        write_reg(9, 32'h00000099);
        #1;
        chk("x9_before_reset", {32'b0, bus.RD1D}, 64'h99);
        chk("instret_8", bus.InstretCount, 64'd8);
        bus.ValidW = 1; bus.RegWriteW = 1; bus.RdW = 9; bus.ALUResultW = 32'h55;
        #1 reset_n = 0;
        bus.ValidW = 0; bus.RegWriteW = 0;
        #1;
        chk("midreset_instret", bus.InstretCount, 64'd0);
        chk("midreset_x9", {32'b0, bus.RD1D}, 64'd0);
        step();
        chk("held_x9", {32'b0, bus.RD1D}, 64'd0);
        #2 reset_n = 1;
        #1;
        chk("postreset_instret", bus.InstretCount, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
